count1_sweep_ctrl: RTL
======================

// Module: count1_sweep_ctrl
// PURPOSE
//  Upstream sequencer for the count-ones GDP. Walks operands START..STOP into n_in.
//  Per operand: runs the start/done/restart handshake, collects runSum, and keeps sweep totals.
//  Synthesizable replacement for bench-driven stimulus; sits directly before the GDP.
// PARAMETERS
//  START    0    first operand (8-bit)
//  STOP     255  last operand, inclusive; START <= STOP required
//  TIMEOUT  64   max cycles in WAIT before abort
// PORTS
//  clock        in   1   system clock, rising edge
//  restart      in   1   asynchronous, active-high reset
//  go           in   1   begin sweep; sampled in IDLE/FINISH only
//  run_sum      in   8   GDP runSum
//  gdp_done     in   1   GDP done
//  n_out        out  8   operand to GDP n_in
//  gdp_start    out  1   to GDP start
//  gdp_restart  out  1   to GDP restart
//  total        out  16  sum of all captured run_sum this sweep
//  ops          out  9   operands completed this sweep
//  busy         out  1   sweep in progress
//  sweep_done   out  1   sweep ended (normal or timeout), held until next go
//  timeout_err  out  1   sweep aborted by watchdog, held until next go
//  err_cnt      out  9   self-check mismatches (SELF_CHECK_EN only)
// BEHAVIOUR
//  - Reset (restart=1, async): state IDLE; all outputs 0 except n_out=START.
//  - Reset mid-sweep: immediate abort; totals lost; gdp_start drops the same instant.
//  - FSM states: IDLE, LOAD, WAIT, CAPTURE, CLEAR, FINISH.
//  - IDLE/FINISH + go:
//    - clear total, ops, err_cnt, sweep_done, timeout_err; n_out=START; -> LOAD.
//  - LOAD (1 cycle): gdp_start=1, gdp_restart=0, watchdog=0 -> WAIT. gdp_done ignored here.
//  - WAIT: gdp_start held 1.
//    - gdp_done=1 -> CAPTURE.
//    - else watchdog++; watchdog==TIMEOUT-1 -> FINISH with timeout_err=1.
//    - done has priority over timeout in the same cycle.
//  - CAPTURE (1 cycle): total += run_sum (zero-extended, no saturation); ops++ -> CLEAR.
//  - CLEAR (1 cycle): gdp_start=0, gdp_restart=1.
//    - n_out==STOP -> FINISH.
//    - else n_out++ -> LOAD.
//    - STOP is compared before increment, so n_out never wraps at 255.
//  - FINISH: busy=0, sweep_done=1; outputs frozen until go.
//  - busy=1 in LOAD..CLEAR. go while busy is ignored.
//  - gdp_start and gdp_restart are registered outputs; never both 1 in the same cycle.
//  - Overhead per operand: 3 cycles (LOAD, CAPTURE, CLEAR) plus GDP latency.
//  - START==STOP: exactly one operand, ops=1.
// CONFIGURATION
//  SELF_CHECK_EN defined:
//    - CAPTURE also compares run_sum against an internal combinational popcount(n_out).
//    - mismatch -> err_cnt++ (9-bit, no wrap within one sweep).
//  SELF_CHECK_EN undefined:
//    - no reference popcount logic; err_cnt tied to 0.
// TESTING
//  1. Defaults, real GDP, go pulse -> ops=256, total=1024, err_cnt=0, sweep_done=1, timeout_err=0.
//  2. START=STOP=8'hE3 -> one handshake, total=5, ops=1, n_out stays 8'hE3.
//  3. GDP model with done stuck 0 -> timeout_err=1, sweep_done=1, ops=0, TIMEOUT cycles after LOAD.
//  4. restart asserted mid-sweep (ops=40) -> same-cycle async clear; ops=0, total=0, busy=0, gdp_start=0.
//  5. SELF_CHECK_EN, model returns 5 for n=8'hAA, otherwise correct -> err_cnt=1, total=1025.
//  6. go re-pulsed while busy -> ignored; sweep completes with ops=256.

Source files
------------

// File: rtl/count1_sweep_ctrl.sv
// count1_sweep_ctrl: sequencer that walks operands START..STOP into the
// count-ones GDP, runs the start/done/restart handshake per operand and
// accumulates run_sum totals for the sweep.
// Optional feature macro: SELF_CHECK_EN (adds an internal popcount reference
// and an err_cnt mismatch counter; when undefined err_cnt is tied to 0).
module count1_sweep_ctrl #(
  parameter logic [7:0]  START   = 8'd0,
  parameter logic [7:0]  STOP    = 8'd255,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        restart,
  input  logic        go,
  input  logic [7:0]  run_sum,
  input  logic        gdp_done,
  output logic [7:0]  n_out,
  output logic        gdp_start,
  output logic        gdp_restart,
  output logic [15:0] total,
  output logic [8:0]  ops,
  output logic        busy,
  output logic        sweep_done,
  output logic        timeout_err,
  output logic [8:0]  err_cnt
);

  localparam int unsigned N_W   = 8;
  localparam int unsigned TOT_W = 16;
  localparam int unsigned OPS_W = 9;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CAPTURE,
    CLEAR,
    FINISH
  } state_t;

  state_t            state, state_nxt;
  logic [N_W-1:0]    n_out_nxt;
  logic [TOT_W-1:0]  total_nxt;
  logic [OPS_W-1:0]  ops_nxt;
  logic [WD_W-1:0]   wd, wd_nxt;
  logic              sweep_done_nxt;
  logic              timeout_err_nxt;
  logic              gdp_start_nxt;
  logic              gdp_restart_nxt;
  logic              busy_nxt;

`ifdef SELF_CHECK_EN
  logic [3:0]        ref_ones;
  logic [OPS_W-1:0]  err_cnt_q, err_cnt_nxt;

  assign err_cnt = err_cnt_q;

  // Reference popcount of the operand currently presented to the GDP.
  always_comb begin
    ref_ones = 4'd0;
    for (int i = 0; i < N_W; i++) begin
      ref_ones = ref_ones + {3'b000, n_out[i]};
    end
  end
`else
  assign err_cnt = '0;
`endif

  // Next-state and next-output decode; handshake outputs follow the next state.
  always_comb begin
    state_nxt       = state;
    n_out_nxt       = n_out;
    total_nxt       = total;
    ops_nxt         = ops;
    wd_nxt          = wd;
    sweep_done_nxt  = sweep_done;
    timeout_err_nxt = timeout_err;
`ifdef SELF_CHECK_EN
    err_cnt_nxt     = err_cnt_q;
`endif

    case (state)
      IDLE, FINISH: begin
        if (go) begin
          total_nxt       = '0;
          ops_nxt         = '0;
          sweep_done_nxt  = 1'b0;
          timeout_err_nxt = 1'b0;
          n_out_nxt       = START;
`ifdef SELF_CHECK_EN
          err_cnt_nxt     = '0;
`endif
          state_nxt       = LOAD;
        end
      end
      LOAD: begin
        wd_nxt    = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done wins over a watchdog expiry in the same cycle
        if (gdp_done) begin
          state_nxt = CAPTURE;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          timeout_err_nxt = 1'b1;
          sweep_done_nxt  = 1'b1;
          state_nxt       = FINISH;
        end else begin
          wd_nxt = wd + WD_W'(1);
        end
      end
      CAPTURE: begin
        total_nxt = total + TOT_W'(run_sum);
        ops_nxt   = ops + OPS_W'(1);
`ifdef SELF_CHECK_EN
        if ((run_sum != {4'b0000, ref_ones}) && (err_cnt_q != {OPS_W{1'b1}})) begin
          err_cnt_nxt = err_cnt_q + OPS_W'(1);
        end
`endif
        state_nxt = CLEAR;
      end
      CLEAR: begin
        // compare before increment so n_out never wraps past STOP
        if (n_out == STOP) begin
          sweep_done_nxt = 1'b1;
          state_nxt      = FINISH;
        end else begin
          n_out_nxt = n_out + N_W'(1);
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    gdp_start_nxt   = (state_nxt == LOAD) || (state_nxt == WAIT) || (state_nxt == CAPTURE);
    gdp_restart_nxt = (state_nxt == CLEAR);
    busy_nxt        = gdp_start_nxt || gdp_restart_nxt;
  end

  // State and registered outputs; restart aborts everything immediately.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state       <= IDLE;
      n_out       <= START;
      total       <= '0;
      ops         <= '0;
      wd          <= '0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
      gdp_start   <= 1'b0;
      gdp_restart <= 1'b0;
      busy        <= 1'b0;
`ifdef SELF_CHECK_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      n_out       <= n_out_nxt;
      total       <= total_nxt;
      ops         <= ops_nxt;
      wd          <= wd_nxt;
      sweep_done  <= sweep_done_nxt;
      timeout_err <= timeout_err_nxt;
      gdp_start   <= gdp_start_nxt;
      gdp_restart <= gdp_restart_nxt;
      busy        <= busy_nxt;
`ifdef SELF_CHECK_EN
      err_cnt_q   <= err_cnt_nxt;
`endif
    end
  end

endmodule
